branch_predictor_gshare: RTL and testbench
==========================================

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter INDEX_W, default 8, meaning log2 of pattern-table entries; legal range 4..12.
REQ-002 Parameter CTR_W, default 2, meaning saturating-counter width; legal range 2..4.
REQ-003 Parameter HIST_W, default 8, meaning global-history-register width; legal range 1..INDEX_W.
REQ-004 Port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port pred_valid  input  1  fetch lookup request this cycle.
REQ-007 Port pred_pc  input  32  PC of the instruction being fetched.
REQ-008 Port pred_taken  output  1  prediction for pred_pc, combinational from the table.
REQ-009 Port pred_hist  output  HIST_W  GHR value used for this lookup; the pipeline carries it to resolve.
REQ-010 Port upd_valid  input  1  a branch resolves this cycle.
REQ-011 Port upd_pc  input  32  PC of the resolving branch.
REQ-012 Port upd_hist  input  HIST_W  pred_hist snapshot carried with the resolving branch.
REQ-013 Port upd_taken  input  1  actual branch outcome.
REQ-014 Port upd_mispredict  input  1  the earlier prediction was wrong; qualified by upd_valid.
REQ-015 Port ready  output  1  table initialised; predictor operational.

Function
REQ-016 The table SHALL hold 2^INDEX_W counters of CTR_W bits each; pred_taken SHALL equal the MSB of the counter at the lookup index.
REQ-017 Lookup index SHALL be pred_pc[INDEX_W+1:2] XOR the zero-extended GHR; update index SHALL be upd_pc[INDEX_W+1:2] XOR the zero-extended upd_hist.
REQ-018 When upd_valid=1 and ready=1, the indexed counter SHALL increment if upd_taken=1 and decrement otherwise, saturating at 2^CTR_W-1 and at 0.
REQ-019 A lookup and an update to the same index in the same cycle SHALL return the pre-update value; the new value becomes visible on the next cycle. There is no bypass.
REQ-020 When pred_valid=1 and ready=1, the GHR SHALL shift left by one bit and insert pred_taken as the LSB (speculative update).
REQ-021 When upd_valid=1, upd_mispredict=1 and ready=1, the GHR SHALL load {upd_hist[HIST_W-2:0], upd_taken}. For HIST_W=1 it SHALL load upd_taken.
REQ-022 When REQ-020 and REQ-021 apply in the same cycle, REQ-021 SHALL take priority and the speculative shift SHALL be dropped.
REQ-023 pred_hist SHALL equal the current GHR; it does not include the shift caused by this cycle's lookup.
REQ-024 The FSM has two states, INIT and RUN. INIT SHALL write the value 2^(CTR_W-1)-1 (weakly not-taken) to one entry per cycle, with the pointer running from 0 to 2^INDEX_W-1.
REQ-025 The FSM SHALL move from INIT to RUN on the cycle after the last entry is written.
REQ-026 ready SHALL be 1 only in RUN.
REQ-027 In INIT, pred_taken SHALL be 0, pred_hist SHALL be 0, and upd_valid and pred_valid SHALL be ignored.
REQ-028 Counter arithmetic SHALL be CTR_W-bit unsigned with no wrap-around.

Reset
REQ-029 While rst_n=0 at a rising edge, the next state SHALL be INIT with init pointer 0, GHR 0 and ready 0.
REQ-030 Table contents SHALL NOT be cleared directly by reset; they are cleared only by the INIT sweep.
REQ-031 Reset asserted during INIT or RUN SHALL restart the sweep from entry 0.
REQ-032 The first usable cycle SHALL be 2^INDEX_W cycles after the first edge with rst_n=1.

Configuration
REQ-033 Macro BP_GSHARE_EN, when defined, SHALL enable the history XOR of REQ-017 and the GHR behaviour of REQ-020 to REQ-022.
REQ-034 When BP_GSHARE_EN is undefined, both indices SHALL be the PC bits only (bimodal). The GHR SHALL be held at 0, pred_hist SHALL be driven 0, and upd_hist SHALL be ignored. All other behaviour is unchanged.

Verification (defaults, BP_GSHARE_EN defined unless noted)
REQ-035 Release reset -> ready=0 for 256 cycles and 1 from the 257th; in RUN, a lookup on pred_pc 0x0 with GHR=0 gives pred_taken=0 (counter 01).
REQ-036 upd_pc=0x40, upd_hist=0, upd_taken=1 three times -> counter goes 01, 10, 11, 11; pred_taken for pc 0x40 with GHR=0 becomes 1 after the first update. Four not-taken updates -> counter goes 10, 01, 00, 00.
REQ-037 pred_valid=1 for three cycles with pred_taken=1 -> GHR=0x07. Next cycle, pred_valid=1 together with upd_mispredict=1, upd_hist=0x05, upd_taken=0 -> GHR=0x0A.
REQ-038 Taken update with upd_pc=0x40, upd_hist=0x10 writes index 0x00, so lookup pc 0x0 with GHR 0x00 sees counter 10. With BP_GSHARE_EN undefined, the same update writes index 0x10 instead.
REQ-039 Assert rst_n=0 at sweep pointer 100 -> sweep restarts and ready stays 0 for a further 256 cycles. Assert rst_n=0 in RUN after training -> all counters read 01 after the sweep.
REQ-040 Same-cycle lookup and taken update at index 0x20 with counter 01 -> pred_taken=0 that cycle and 1 on the next cycle.

Source files
------------

// File: rtl/branch_predictor_gshare_if.sv
// Fetch-lookup and resolve-update bundle for the gshare predictor.
// master drives requests/updates, slave is the predictor.
interface branch_predictor_gshare_if #(
  parameter int HIST_W = 8
);
  logic              pred_valid;
  logic [31:0]       pred_pc;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_hist;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [HIST_W-1:0] upd_hist;
  logic              upd_taken;
  logic              upd_mispredict;
  logic              ready;

  modport master (
    output pred_valid, pred_pc,
    output upd_valid, upd_pc, upd_hist,
    output upd_taken, upd_mispredict,
    input  pred_taken, pred_hist, ready
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  upd_valid, upd_pc, upd_hist,
    input  upd_taken, upd_mispredict,
    output pred_taken, pred_hist, ready
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor with a one-entry-per-cycle init sweep.
// Define BP_GSHARE_EN for global-history indexing; default is bimodal.
module branch_predictor_gshare #(
  parameter int INDEX_W = 8,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  branch_predictor_gshare_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT =
    {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [INDEX_W-1:0] ptr;
  logic               rdy;
  logic [HIST_W-1:0]  ghr;
  logic [INDEX_W-1:0] pidx;
  logic [INDEX_W-1:0] uidx;
  logic [CTR_W-1:0]   ctr_cur;
  logic [CTR_W-1:0]   ctr_nxt;
  logic               taken;
  logic [CTR_W-1:0]   tbl [ENTRIES];
  logic               unused_bits;

  assign unused_bits = ^{bus.pred_pc[31:INDEX_W+2],
                         bus.pred_pc[1:0],
                         bus.upd_pc[31:INDEX_W+2],
                         bus.upd_pc[1:0]};

  function automatic logic [HIST_W-1:0] shl(
    input logic [HIST_W-1:0] h,
    input logic              b
  );
    return (h << 1) | HIST_W'(b);
  endfunction

`ifdef BP_GSHARE_EN
  assign pidx = bus.pred_pc[INDEX_W+1:2] ^ INDEX_W'(ghr);
  assign uidx = bus.upd_pc[INDEX_W+1:2] ^ INDEX_W'(bus.upd_hist);

  // Speculative history shift; a mispredict repair wins over it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (rdy) begin
      if (bus.upd_valid && bus.upd_mispredict)
        ghr <= shl(bus.upd_hist, bus.upd_taken);
      else if (bus.pred_valid)
        ghr <= shl(ghr, taken);
    end
  end
`else
  logic unused_ctl;

  assign unused_ctl = ^{bus.upd_hist, bus.upd_mispredict,
                        bus.pred_valid, shl(ghr, taken)};
  assign pidx = bus.pred_pc[INDEX_W+1:2];
  assign uidx = bus.upd_pc[INDEX_W+1:2];
  assign ghr  = '0;
`endif

  assign taken          = rdy & tbl[pidx][CTR_W-1];
  assign bus.pred_taken = taken;
  assign bus.pred_hist  = ghr;
  assign bus.ready      = rdy;

  // Saturating step of the counter addressed by the resolving branch.
  always_comb begin
    ctr_cur = tbl[uidx];
    ctr_nxt = ctr_cur;
    unique case (1'b1)
      (bus.upd_taken && ctr_cur != CTR_MAX):
        ctr_nxt = ctr_cur + CTR_W'(1);
      (!bus.upd_taken && ctr_cur != '0):
        ctr_nxt = ctr_cur - CTR_W'(1);
      default: ;
    endcase
  end

  // INIT sweeps the pointer over every entry, then enters RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          ptr <= ptr + INDEX_W'(1);
          if (ptr == '1) begin
            state <= RUN;
            rdy   <= 1'b1;
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase
    end
  end

  // Table storage: sweep writes in INIT, training writes in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT)
        tbl[ptr] <= CTR_INIT;
      else if (bus.upd_valid)
        tbl[uidx] <= ctr_nxt;
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench for branch_predictor_gshare.
// Expectations adapt to whether BP_GSHARE_EN is defined.
module tb_branch_predictor_gshare;
  localparam int HW = 8;
  localparam int K_TAKEN = 0;
  localparam int K_HIST  = 1;
  localparam int K_READY = 2;
`ifdef BP_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.HIST_W(HW)) bus();

  branch_predictor_gshare #(
    .INDEX_W(8),
    .CTR_W(2),
    .HIST_W(HW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string n, input int k,
                      input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.kind = k;
    x.exp  = e;
    sbq.push_back(x);
  endtask

  // Monitor: pops every expectation posted this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_TAKEN: act = {31'b0, bus.pred_taken};
        K_HIST:  act = 32'(bus.pred_hist);
        default: act = {31'b0, bus.ready};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s got %0h want %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pred_valid     = 1'b0;
    bus.pred_pc        = 32'h0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = 32'h0;
    bus.upd_hist       = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic do_upd(input logic [31:0] pc,
                        input logic [HW-1:0] h,
                        input logic t, input logic m);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_hist       = h;
    bus.upd_taken      = t;
    bus.upd_mispredict = m;
    cyc();
    bus.upd_valid      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic probe(input logic [31:0] pc, input logic e,
                       input string n);
    bus.pred_pc = pc;
    push(n, K_TAKEN, {31'b0, e});
    cyc();
  endtask

  logic t_seq [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
  logic e_seq [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) cyc();
    push("rst_ready", K_READY, 0);
    push("rst_taken", K_TAKEN, 0);
    push("rst_hist", K_HIST, 0);
    rst_n = 1'b1;
    // Traffic during INIT must be ignored.
    bus.pred_valid     = 1'b1;
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = 32'h100;
    bus.upd_hist       = 8'hFF;
    bus.upd_taken      = 1'b1;
    bus.upd_mispredict = 1'b1;
    cyc();
    for (int i = 1; i < 255; i++) begin
      if (i == 100) begin
        push("init_taken", K_TAKEN, 0);
        push("init_hist", K_HIST, 0);
      end
      cyc();
    end
    push("ready_255", K_READY, 0);
    idle();
    cyc();
    push("ready_256", K_READY, 1);
    push("run_hist", K_HIST, 0);
    probe(32'h0, 1'b0, "run_pc0");

    // Saturation up and down at pc 0x40.
    for (int i = 0; i < 9; i++) begin
      do_upd(32'h40, '0, t_seq[i], 1'b0);
      probe(32'h40, e_seq[i], $sformatf("sat_%0d", i));
    end

    // Same-cycle lookup and update: no bypass.
    bus.pred_pc   = 32'h80;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h80;
    bus.upd_hist  = '0;
    bus.upd_taken = 1'b1;
    push("same_cyc", K_TAKEN, 0);
    cyc();
    bus.upd_valid = 1'b0;
    probe(32'h80, 1'b1, "next_cyc");

    // History: train 0x30/0x31/0x33, then shift three taken.
    do_upd(32'hC0, '0, 1'b1, 1'b0);
    do_upd(32'hC4, '0, 1'b1, 1'b0);
    do_upd(32'hCC, '0, 1'b1, 1'b0);
    bus.pred_valid = 1'b1;
    bus.pred_pc    = 32'hC0;
    push("ghr_t0", K_TAKEN, 1);
    push("ghr_h0", K_HIST, 0);
    cyc();
    push("ghr_t1", K_TAKEN, 1);
    push("ghr_h1", K_HIST, GS ? 32'h1 : 32'h0);
    cyc();
    push("ghr_t2", K_TAKEN, 1);
    push("ghr_h2", K_HIST, GS ? 32'h3 : 32'h0);
    cyc();
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = 32'h3FC;
    bus.upd_hist       = 8'h05;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b1;
    push("ghr_h3", K_HIST, GS ? 32'h7 : 32'h0);
    cyc();
    idle();
    push("ghr_repair", K_HIST, GS ? 32'h0A : 32'h0);
    cyc();
    do_upd(32'h3FC, '0, 1'b0, 1'b1);
    push("ghr_zero", K_HIST, 0);
    cyc();

    // Reset in RUN, then again mid-sweep at pointer 100.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (100) cyc();
    rst_n = 1'b0;
    push("rst2_ready", K_READY, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    repeat (254) cyc();
    push("rst2_255", K_READY, 0);
    cyc();
    push("rst2_256", K_READY, 1);
    push("rst2_hist", K_HIST, 0);
    probe(32'h40, 1'b0, "clr_40");
    probe(32'hC0, 1'b0, "clr_C0");
    probe(32'h80, 1'b0, "clr_80");

    // History-folded update index.
    do_upd(32'h40, 8'h10, 1'b1, 1'b0);
    probe(32'h0, GS, "xor_idx0");
    probe(32'h40, !GS, "xor_idx10");

    repeat (2) cyc();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
